io_bus_ctrl: RTL

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

---
 rtl/io_bus_pkg.sv | 23 ++
 rtl/tcount.sv | 34 +++
 rtl/io_bus_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the io_bus_ctrl peripheral bus master:
// FSM state encoding, default strobe timings and timer width.
package io_bus_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StHold   = 2'd3
    } state_e;

    localparam int unsigned TSetupDef  = 1;
    localparam int unsigned TStrobeDef = 2;
    localparam int unsigned THoldDef   = 1;

    localparam int unsigned TimerWidth = 4;

    // A phase of T cycles is timed by loading T-1 and leaving when the count hits zero.
    function automatic logic [TimerWidth-1:0] tick_load(input int unsigned t);
        return TimerWidth'(t - 1);
    endfunction

endpackage

// File: rtl/tcount.sv
// Loadable down-counter with a zero flag, used to time each bus phase.
module tcount
    import io_bus_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [TimerWidth-1:0] load_val_i,
    output logic                  zero_o
);

    logic [TimerWidth-1:0] cnt_q, cnt_d;

    // Saturates at zero so an idle timer stays parked.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/io_bus_ctrl.sv
// Peripheral bus master: runs one SETUP/STROBE/HOLD chip-select cycle per accepted request,
// driving registered strobes and capturing read data at the end of the strobe.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 2,
    parameter int unsigned TSETUP   = TSetupDef,
    parameter int unsigned TSTROBE  = TStrobeDef,
    parameter int unsigned THOLD    = THoldDef
) (
    input  logic                CLK,
    input  logic                RST_,
    input  logic                REQ,
    input  logic                WE,
    input  logic [ADDRSIZE-1:0] AIN,
    input  logic [DATASIZE-1:0] DIN,
    output logic [DATASIZE-1:0] DOUT,
    output logic                BUSY,
    output logic                DONE,
    output logic                CS_,
    output logic                RD_,
    output logic                WR_,
    output logic [ADDRSIZE-1:0] ADDR,
    inout  wire  [DATASIZE-1:0] DATA
);

    state_e                state_q, state_d;
    logic                  accept;
    logic                  we_q, we_d;
    logic [ADDRSIZE-1:0]   addr_q, addr_d;
    logic [DATASIZE-1:0]   din_q, din_d;
    logic [DATASIZE-1:0]   dout_q, dout_d;
    logic                  cs_n_q, cs_n_d;
    logic                  rd_n_q, rd_n_d;
    logic                  wr_n_q, wr_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  oe_q, oe_d;
    logic                  tmr_load;
    logic [TimerWidth-1:0] tmr_val;
    logic                  tmr_zero;

    tcount u_tcount (
        .clk_i      (CLK),
        .rst_ni     (RST_),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign accept = (state_q == StIdle) && REQ;

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    state_d  = StSetup;
                    tmr_load = 1'b1;
                    tmr_val  = tick_load(TSETUP);
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    state_d  = StStrobe;
                    tmr_load = 1'b1;
                    tmr_val  = tick_load(TSTROBE);
                end
            end
            StStrobe: begin
                if (tmr_zero) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = tick_load(THOLD);
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are computed from the next state so they leave flops, not decode logic.
    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        din_d  = din_q;
        dout_d = dout_q;
        if (accept) begin
            we_d   = WE;
            addr_d = AIN;
            din_d  = DIN;
        end
        if ((state_q == StStrobe) && tmr_zero && !we_q) begin
            dout_d = DATA;
        end
        busy_d = (state_d != StIdle);
        cs_n_d = ~busy_d;
        rd_n_d = ~((state_d == StStrobe) && !we_d);
        wr_n_d = ~((state_d == StStrobe) && we_d);
        oe_d   = busy_d && we_d;
        done_d = (state_q == StHold) && (state_d == StIdle);
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
        end
    end

    assign DOUT = dout_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign CS_  = cs_n_q;
    assign RD_  = rd_n_q;
    assign WR_  = wr_n_q;
    assign ADDR = addr_q;
    assign DATA = oe_q ? din_q : {DATASIZE{1'bz}};

endmodule
